// File: rtl/cv32e40x_rvfi_trace_ctrl.sv
// Trace-window controller and record FIFO between the RVFI retirement
// interface and a trace sink. Selects retirements using arm/stop controls,
// start/stop PC triggers and a record limit. Qualifying records are buffered
// and drained over valid/ready. Capture, drop and overflow statistics are kept.
module cv32e40x_rvfi_trace_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_arm_i,
  input  logic                       cfg_stop_i,
  input  logic                       cfg_start_en_i,
  input  logic [31:0]                cfg_start_pc_i,
  input  logic [31:0]                cfg_stop_pc_i,
  input  logic [CNT_W-1:0]           cfg_max_i,
  input  logic                       rvfi_valid,
  input  logic [31:0]                rvfi_pc_rdata,
  input  logic [4:0]                 rvfi_rd_addr,
  input  logic [31:0]                rvfi_rd_wdata,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_pc_o,
  output logic [4:0]                 out_rd_addr_o,
  output logic [31:0]                out_rd_wdata_o,
  output logic [1:0]                 state_o,
  output logic [CNT_W-1:0]           count_o,
  output logic [CNT_W-1:0]           drop_cnt_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH):0]     fifo_level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned REC_W = 32 + 5 + 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             rec_done;
  logic             capture;

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] level_after_pop;
  logic [REC_W-1:0] head_q, head_d;
  logic [REC_W-1:0] rec_in;
  logic             fifo_full;
  logic             push;
  logic             pop;

  assign rec_in    = {rvfi_pc_rdata, rvfi_rd_addr, rvfi_rd_wdata};
  assign fifo_full = (level_q == LVL_FULL);
  assign pop       = (level_q != '0) && out_ready_i;
  assign push      = capture && !fifo_full;

  // Window FSM, capture qualification and statistics update
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    capture  = 1'b0;
    cnt_inc  = count_q + CNT_ONE;
    rec_done = (rvfi_pc_rdata == cfg_stop_pc_i) ||
               ((cfg_max_i != '0) && (cnt_inc == cfg_max_i));

    if (cfg_stop_i) begin
      state_d = IDLE;
    end else if (cfg_arm_i && ((state_q == IDLE) || (state_q == DONE))) begin
      state_d = ARMED;
      count_d = '0;
      drop_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (!cfg_start_en_i) begin
            state_d = ACTIVE;
          end else if (rvfi_valid && (rvfi_pc_rdata == cfg_start_pc_i)) begin
            // The start-matching retirement is itself captured and may also
            // end the window (stop PC or a limit of one).
            capture = 1'b1;
            state_d = rec_done ? DONE : ACTIVE;
          end
        end
        ACTIVE: begin
          if (rvfi_valid) begin
            capture = 1'b1;
            if (rec_done) begin
              state_d = DONE;
            end
          end
        end
        default: ;
      endcase
    end

    if (capture) begin
      count_d = cnt_inc;
      if (fifo_full) begin
        if (drop_q != '1) begin
          drop_d = drop_q + CNT_ONE;
        end
        ovf_d = 1'b1;
      end
    end
  end

  // FIFO pointer, occupancy and registered head computation
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    level_after_pop = pop ? (level_q - LVL_ONE) : level_q;

    // Head register is preloaded with the entry that will be at the front
    // next cycle; a push into an otherwise empty FIFO bypasses the array.
    if (push && (level_after_pop == '0)) begin
      head_d = rec_in;
    end else if (level_d != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else begin
      head_d = head_q;
    end
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  // Record storage array; contents are only meaningful below the occupancy
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rec_in;
    end
  end

  assign out_valid_o    = (level_q != '0);
  assign out_pc_o       = head_q[REC_W-1 -: 32];
  assign out_rd_addr_o  = head_q[36:32];
  assign out_rd_wdata_o = head_q[31:0];
  assign state_o        = state_q;
  assign count_o        = count_q;
  assign drop_cnt_o     = drop_q;
  assign overflow_o     = ovf_q;
  assign fifo_level_o   = level_q;

endmodule

// File: tb/tb_cv32e40x_rvfi_trace_ctrl.sv
// Directed bench for the RVFI trace-window controller.
module tb_cv32e40x_rvfi_trace_ctrl;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_arm_i, cfg_stop_i, cfg_start_en_i;
  logic [31:0]       cfg_start_pc_i, cfg_stop_pc_i;
  logic [CNT_W-1:0]  cfg_max_i;
  logic              rvfi_valid;
  logic [31:0]       rvfi_pc_rdata;
  logic [4:0]        rvfi_rd_addr;
  logic [31:0]       rvfi_rd_wdata;
  logic              out_valid_o, out_ready_i;
  logic [31:0]       out_pc_o;
  logic [4:0]        out_rd_addr_o;
  logic [31:0]       out_rd_wdata_o;
  logic [1:0]        state_o;
  logic [CNT_W-1:0]  count_o, drop_cnt_o;
  logic              overflow_o;
  logic [3:0]        fifo_level_o;

  int total = 0;
  int bad   = 0;

  cv32e40x_rvfi_trace_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_arm_i      (cfg_arm_i),
    .cfg_stop_i     (cfg_stop_i),
    .cfg_start_en_i (cfg_start_en_i),
    .cfg_start_pc_i (cfg_start_pc_i),
    .cfg_stop_pc_i  (cfg_stop_pc_i),
    .cfg_max_i      (cfg_max_i),
    .rvfi_valid     (rvfi_valid),
    .rvfi_pc_rdata  (rvfi_pc_rdata),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_pc_o       (out_pc_o),
    .out_rd_addr_o  (out_rd_addr_o),
    .out_rd_wdata_o (out_rd_wdata_o),
    .state_o        (state_o),
    .count_o        (count_o),
    .drop_cnt_o     (drop_cnt_o),
    .overflow_o     (overflow_o),
    .fifo_level_o   (fifo_level_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic retire(input logic [31:0] pc);
    rvfi_valid    = 1'b1;
    rvfi_pc_rdata = pc;
    rvfi_rd_addr  = pc[6:2];
    rvfi_rd_wdata = ~pc;
    tick();
    rvfi_valid    = 1'b0;
  endtask

  task automatic pulse_arm();
    cfg_arm_i = 1'b1;
    tick();
    cfg_arm_i = 1'b0;
  endtask

  // Drains n records with consecutive PCs starting at first, then expects empty.
  task automatic drain(input string tag, input logic [31:0] first, input int n);
    logic [31:0] pc;
    out_ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      pc = first + 32'(4 * i);
      chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
      chk({tag, "_pc"}, out_pc_o, pc);
      chk({tag, "_rd"}, 32'(out_rd_addr_o), 32'(pc[6:2]));
      chk({tag, "_wdata"}, out_rd_wdata_o, ~pc);
      tick();
    end
    chk({tag, "_empty"}, 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_arm_i = 1'b0; cfg_stop_i = 1'b0; cfg_start_en_i = 1'b0;
    cfg_start_pc_i = '0; cfg_stop_pc_i = 32'hFFFF_FFFF; cfg_max_i = '0;
    rvfi_valid = 1'b0; rvfi_pc_rdata = '0; rvfi_rd_addr = '0; rvfi_rd_wdata = '0;
    out_ready_i = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_drop", 32'(drop_cnt_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_level", 32'(fifo_level_o), 32'd0);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_pc", out_pc_o, 32'd0);

    // Immediate start, streaming sink
    out_ready_i = 1'b1;
    pulse_arm();
    chk("imm_armed", 32'(state_o), 32'd1);
    tick();
    chk("imm_active", 32'(state_o), 32'd2);
    retire(32'h100);
    chk("imm_pc0", out_pc_o, 32'h100);
    chk("imm_lvl0", 32'(fifo_level_o), 32'd1);
    retire(32'h104);
    chk("imm_pc1", out_pc_o, 32'h104);
    retire(32'h108);
    chk("imm_pc2", out_pc_o, 32'h108);
    chk("imm_wd2", out_rd_wdata_o, ~32'h108);
    tick();
    chk("imm_count", 32'(count_o), 32'd3);
    chk("imm_drop", 32'(drop_cnt_o), 32'd0);
    chk("imm_empty", 32'(out_valid_o), 32'd0);

    // Start/stop PC triggers
    cfg_stop_i = 1'b1; tick(); cfg_stop_i = 1'b0;
    chk("trg_idle", 32'(state_o), 32'd0);
    out_ready_i = 1'b0;
    cfg_start_en_i = 1'b1; cfg_start_pc_i = 32'h200; cfg_stop_pc_i = 32'h20C;
    pulse_arm();
    chk("trg_armed", 32'(state_o), 32'd1);
    chk("trg_cnt_clr", 32'(count_o), 32'd0);
    retire(32'h1F8);
    chk("trg_wait", 32'(state_o), 32'd1);
    chk("trg_lvl_wait", 32'(fifo_level_o), 32'd0);
    retire(32'h200);
    chk("trg_start", 32'(state_o), 32'd2);
    chk("trg_cnt1", 32'(count_o), 32'd1);
    retire(32'h204);
    retire(32'h208);
    retire(32'h20C);
    chk("trg_done", 32'(state_o), 32'd3);
    retire(32'h210);
    chk("trg_count", 32'(count_o), 32'd4);
    chk("trg_level", 32'(fifo_level_o), 32'd4);
    drain("trg_drain", 32'h200, 4);

    // Record limit
    cfg_start_en_i = 1'b0; cfg_stop_pc_i = 32'hFFFF_FFFF; cfg_max_i = 16'd2;
    pulse_arm();
    tick();
    chk("lim_active", 32'(state_o), 32'd2);
    for (int i = 0; i < 5; i++) retire(32'h300 + 32'(4 * i));
    chk("lim_done", 32'(state_o), 32'd3);
    chk("lim_count", 32'(count_o), 32'd2);
    tick();
    chk("lim_empty", 32'(fifo_level_o), 32'd0);
    pulse_arm();
    chk("lim_rearm_cnt", 32'(count_o), 32'd0);
    chk("lim_rearm_st", 32'(state_o), 32'd1);

    // Overflow with stalled sink
    cfg_max_i = '0;
    out_ready_i = 1'b0;
    tick();
    for (int i = 0; i < 11; i++) retire(32'h400 + 32'(4 * i));
    chk("ovf_level", 32'(fifo_level_o), 32'd8);
    chk("ovf_drop", 32'(drop_cnt_o), 32'd3);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    chk("ovf_count", 32'(count_o), 32'd11);
    drain("ovf_drain", 32'h400, 8);

    // Full FIFO with simultaneous pop and capture
    out_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) retire(32'h500 + 32'(4 * i));
    chk("fp_full", 32'(fifo_level_o), 32'd8);
    out_ready_i = 1'b1;
    retire(32'h600);
    chk("fp_level", 32'(fifo_level_o), 32'd7);
    chk("fp_drop", 32'(drop_cnt_o), 32'd4);
    chk("fp_count", 32'(count_o), 32'd20);
    drain("fp_drain", 32'h504, 7);

    // Stop mid-window with a same-cycle retirement
    out_ready_i = 1'b0;
    retire(32'h700);
    retire(32'h704);
    cfg_stop_i = 1'b1;
    retire(32'h708);
    cfg_stop_i = 1'b0;
    chk("stp_idle", 32'(state_o), 32'd0);
    chk("stp_level", 32'(fifo_level_o), 32'd2);
    chk("stp_count", 32'(count_o), 32'd22);
    drain("stp_drain", 32'h700, 2);

    // Reset with a partially filled FIFO
    out_ready_i = 1'b0;
    pulse_arm();
    tick();
    for (int i = 0; i < 5; i++) retire(32'h800 + 32'(4 * i));
    chk("rr_level5", 32'(fifo_level_o), 32'd5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rr_level", 32'(fifo_level_o), 32'd0);
    chk("rr_valid", 32'(out_valid_o), 32'd0);
    chk("rr_state", 32'(state_o), 32'd0);
    chk("rr_count", 32'(count_o), 32'd0);
    chk("rr_pc", out_pc_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40x_rvfi_trace_ctrl.md
Name: cv32e40x_rvfi_trace_ctrl

Overview:
- Synthesizable trace-window controller and record buffer placed between the RVFI retirement interface and a trace sink (log writer or debug trace port).
- Decides which retired instructions are traced, using arm/stop controls, a start PC trigger, a stop PC trigger and a record limit.
- Buffers qualifying records in a FIFO and drains them to the sink over a valid/ready handshake.
- Keeps capture, drop and overflow statistics.

Parameters:
- DEPTH, 8: FIFO depth in records; power of 2, at least 2.
- CNT_W, 16: width of the record and drop counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_arm_i  in  1  single-cycle pulse: arm the trace window
- cfg_stop_i  in  1  single-cycle pulse: abort and return to IDLE
- cfg_start_en_i  in  1  1 = wait for start PC; 0 = start immediately when armed
- cfg_start_pc_i  in  32  start trigger PC
- cfg_stop_pc_i  in  32  stop trigger PC
- cfg_max_i  in  CNT_W  window record limit; 0 = unlimited
- rvfi_valid  in  1  instruction retired this cycle
- rvfi_pc_rdata  in  32  PC of retired instruction
- rvfi_rd_addr  in  5  destination register
- rvfi_rd_wdata  in  32  destination write data
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  sink accepts head
- out_pc_o  out  32  head PC
- out_rd_addr_o  out  5  head rd
- out_rd_wdata_o  out  32  head rd data
- state_o  out  2  IDLE=0, ARMED=1, ACTIVE=2, DONE=3
- count_o  out  CNT_W  qualifying retirements in the current window
- drop_cnt_o  out  CNT_W  records dropped because the FIFO was full; saturating
- overflow_o  out  1  sticky: at least one drop since the last arm
- fifo_level_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=1 at a clk edge):
  - state IDLE; count_o, drop_cnt_o, overflow_o = 0.
  - FIFO empty; out_valid_o = 0; out_* data = 0; fifo_level_o = 0.
- Priority each cycle: cfg_stop_i over cfg_arm_i over triggers.
- cfg_stop_i: next state IDLE from any state; a retirement in the same cycle is not captured.
- cfg_arm_i, accepted in IDLE or DONE only (ignored in ARMED and ACTIVE):
  - next state ARMED.
  - clears count_o, drop_cnt_o and overflow_o.
  - does not flush the FIFO.
- ARMED:
  - cfg_start_en_i=0: ACTIVE next cycle; retirements during the ARMED cycle are not captured.
  - cfg_start_en_i=1: stays ARMED until rvfi_valid and pc==cfg_start_pc_i. That retirement is captured in the same cycle and the state moves to ACTIVE.
- ACTIVE: every rvfi_valid is a qualifying retirement and is captured.
  - Stop trigger: capture of a record with pc==cfg_stop_pc_i moves the state to DONE.
  - Limit: if cfg_max_i!=0 and the post-increment count equals cfg_max_i, the state moves to DONE.
  - Both conditions together: DONE; the record is captured once.
  - A start-PC match in the same cycle as the stop-PC match is still a capture followed by DONE.
- Capture:
  - count_o increments by 1, wrapping at 2^CNT_W.
  - FIFO not full: push {pc, rd_addr, rd_wdata}.
  - FIFO full: record dropped; drop_cnt_o increments, saturating at all ones; overflow_o set.
  - Fullness is judged on registered occupancy before any same-cycle pop. When full, a push is dropped even if a pop happens that cycle.
- FIFO:
  - Circular buffer with read and write pointers of width $clog2(DEPTH), wrapping at DEPTH.
  - Occupancy ranges 0..DEPTH.
  - A push to an empty FIFO raises out_valid_o on the next cycle (1-cycle latency).
  - Pop occurs when out_valid_o && out_ready_i; the next entry is presented the following cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO: level unchanged.
  - out_* stay stable while out_valid_o && !out_ready_i.
  - Drains in every state; only rst flushes it.
- The block never writes out_* data when the FIFO is empty; data hold the last value. Verification checks data only while out_valid_o=1.

Test Plan:
- Immediate start: arm with start_en=0, max=0; retire PCs 0x100,0x104,0x108 with out_ready=1 → ACTIVE one cycle after arm; three records exit in order; count_o=3; drop_cnt_o=0.
- Start/stop triggers: start_pc=0x200, stop_pc=0x20C, start_en=1; retire 0x1F8,0x200,0x204,0x208,0x20C,0x210 → exactly 0x200..0x20C captured (count_o=4); state DONE after 0x20C; 0x210 not captured.
- Limit: max=2, start_en=0; retire 5 instructions → 2 captured, then DONE, count_o=2; re-arm clears count_o to 0.
- Overflow, DEPTH=8, out_ready=0: retire 11 in ACTIVE → fifo_level_o=8, drop_cnt_o=3, overflow_o=1. Then set out_ready=1 → the first 8 PCs drain in order and out_valid_o drops after the 8th.
- Full plus same-cycle pop: FIFO full, out_ready=1 and rvfi_valid=1 in the same cycle → pop occurs, push dropped, level 7, drop_cnt_o +1.
- Stop/reset mid-window:
  - cfg_stop_i with rvfi_valid in ACTIVE → IDLE next cycle; that record not captured; FIFO contents still drain.
  - rst with a FIFO of 5 entries → level 0, out_valid_o=0, state IDLE.
